// File: rtl/clk_fwd_div.sv
// Multi-channel forwarded-clock generator: per-channel rise/fall data pairs for an ODDR,
// dividing clk_in by any H with exact 50% duty and period-boundary-only divisor/enable changes.

module clk_fwd_div_ch #(
  parameter int DIV_W   = 8,
  parameter int RST_DIV = 1
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             ld,
  input  logic [DIV_W-1:0] div_in,
  input  logic             sync,
  output logic             q_rise,
  output logic             q_fall,
  output logic             running,
  output logic             pstb,
  output logic             ld_pend
);

  logic             run_q, run_d;
  logic [DIV_W-1:0] c_q, c_d;
  logic [DIV_W-1:0] cur_h_q, cur_h_d;
  logic [DIV_W-1:0] pend_h_q, pend_h_d;
  logic             lp_q, lp_d;
  logic             qr_q, qr_d, qf_q, qf_d, ps_q, ps_d;

  logic [DIV_W-1:0] slot, h_raw, h;
  logic             bnd, go;

  always_comb begin
    // sync forces the slot about to be driven back to 0, which makes this edge a boundary
    slot  = (run_q && sync) ? '0 : c_q;
    bnd   = (slot == '0);
    h_raw = cur_h_q;
    if (run_q && bnd && lp_q) h_raw = pend_h_q;
    if (!run_q && ld)         h_raw = div_in;
    h     = (h_raw == '0) ? DIV_W'(1) : h_raw;
    go    = run_q ? (!bnd || en || sync) : en;

    run_d    = 1'b0;
    c_d      = '0;
    qr_d     = 1'b0;
    qf_d     = 1'b0;
    ps_d     = 1'b0;
    cur_h_d  = cur_h_q;
    pend_h_d = pend_h_q;
    lp_d     = lp_q;

    if (go) begin
      run_d = 1'b1;
      qr_d  = ({slot, 1'b0} < {1'b0, h});
      qf_d  = ({slot, 1'b1} < {1'b0, h});
      ps_d  = bnd;
      c_d   = (slot == h - 1'b1) ? '0 : slot + 1'b1;
    end

    // Old pending value lands at the boundary; a same-edge load becomes the new pending value.
    // A load on the edge that stops the channel behaves like an idle load.
    if (run_q) begin
      if (bnd) begin
        if (lp_q) cur_h_d = pend_h_q;
        lp_d = 1'b0;
      end
      if (ld) begin
        if (go) begin
          pend_h_d = div_in;
          lp_d     = 1'b1;
        end else begin
          cur_h_d = div_in;
        end
      end
    end else if (ld) begin
      cur_h_d = div_in;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= 1'b0;
      c_q      <= '0;
      cur_h_q  <= DIV_W'(RST_DIV);
      pend_h_q <= '0;
      lp_q     <= 1'b0;
      qr_q     <= 1'b0;
      qf_q     <= 1'b0;
      ps_q     <= 1'b0;
    end else begin
      run_q    <= run_d;
      c_q      <= c_d;
      cur_h_q  <= cur_h_d;
      pend_h_q <= pend_h_d;
      lp_q     <= lp_d;
      qr_q     <= qr_d;
      qf_q     <= qf_d;
      ps_q     <= ps_d;
    end
  end

  assign q_rise  = qr_q;
  assign q_fall  = qf_q;
  assign running = run_q;
  assign pstb    = ps_q;
  assign ld_pend = lp_q;

endmodule

module clk_fwd_div #(
  parameter int NUM_CH  = 2,
  parameter int DIV_W   = 8,
  parameter int RST_DIV = 1
) (
  input  logic                    clk_in,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       ld,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       q_rise,
  output logic [NUM_CH-1:0]       q_fall,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       pstb,
  output logic [NUM_CH-1:0]       ld_pend
);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    clk_fwd_div_ch #(
      .DIV_W  (DIV_W),
      .RST_DIV(RST_DIV)
    ) u_ch (
      .clk_in (clk_in),
      .reset_n(reset_n),
      .en     (en[n]),
      .ld     (ld[n]),
      .div_in (div_in[n*DIV_W +: DIV_W]),
      .sync   (sync),
      .q_rise (q_rise[n]),
      .q_fall (q_fall[n]),
      .running(running[n]),
      .pstb   (pstb[n]),
      .ld_pend(ld_pend[n])
    );
  end

endmodule

// File: tb/tb_clk_fwd_div.sv
// Scoreboard bench for clk_fwd_div: expected slot tuples are queued as stimulus is driven
// and popped one cycle later when the registered outputs appear.

module tb_clk_fwd_div;
  localparam int NUM_CH = 2;
  localparam int DIV_W  = 8;

  typedef struct packed {
    logic [1:0] qr;
    logic [1:0] qf;
    logic [1:0] ps;
    logic [1:0] rn;
    logic [1:0] lp;
  } obs_t;

  typedef struct {
    logic [1:0]  en;
    logic [1:0]  ld;
    logic        sy;
    logic [15:0] dv;
    obs_t        ex;
  } step_t;

  logic                    clk_in = 1'b0;
  logic                    reset_n;
  logic [NUM_CH-1:0]       en, ld, q_rise, q_fall, running, pstb, ld_pend;
  logic [NUM_CH*DIV_W-1:0] div_in;
  logic                    sync;
  obs_t                    obs;

  obs_t  sb[$];
  step_t plan[$];
  int    n_chk = 0;
  int    n_fail = 0;

  clk_fwd_div #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_DIV(1)) dut (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .en     (en),
    .ld     (ld),
    .div_in (div_in),
    .sync   (sync),
    .q_rise (q_rise),
    .q_fall (q_fall),
    .running(running),
    .pstb   (pstb),
    .ld_pend(ld_pend)
  );

  always #5 clk_in = ~clk_in;
  assign obs = {q_rise, q_fall, pstb, running, ld_pend};

  function automatic obs_t o(logic [1:0] qr, logic [1:0] qf, logic [1:0] ps,
                             logic [1:0] rn, logic [1:0] lp);
    return {qr, qf, ps, rn, lp};
  endfunction

  function automatic void add(logic [1:0] e, logic [1:0] l, logic s, logic [15:0] d, obs_t x);
    step_t st;
    st.en = e; st.ld = l; st.sy = s; st.dv = d; st.ex = x;
    plan.push_back(st);
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    reset_n = 1'b0; en = '0; ld = '0; sync = 1'b0; div_in = '0;
    repeat (2) tick();
    sb.push_back('0);
    e = sb.pop_front(); n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL reset obs=%h exp=%h", obs, e); end
    reset_n = 1'b1;
    sb.push_back('0);
    tick();
    e = sb.pop_front(); n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_idle obs=%h exp=%h", obs, e); end
  endtask

  task automatic test_h1();
    obs_t e;
    for (int i = 0; i < 6; i++) add(2'b01, 2'b00, 1'b0, 16'd0, o(2'b01, 2'b00, 2'b01, 2'b01, 2'b00));
    add(2'b00, 2'b00, 1'b0, 16'd0, '0);
    add(2'b00, 2'b01, 1'b0, 16'd0, '0);                       // H=0 loaded, acts as H=1
    for (int i = 0; i < 3; i++) add(2'b01, 2'b00, 1'b0, 16'd0, o(2'b01, 2'b00, 2'b01, 2'b01, 2'b00));
    add(2'b00, 2'b00, 1'b0, 16'd0, '0);
    for (int i = 0; plan.size() > 0; i++) begin
      step_t p = plan.pop_front();
      en = p.en; ld = p.ld; sync = p.sy; div_in = p.dv;
      sb.push_back(p.ex);
      tick();
      e = sb.pop_front(); n_chk++;
      if (obs !== e) begin n_fail++; $display("FAIL h1[%0d] obs=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_h3();
    obs_t e;
    obs_t pat[3];
    pat[0] = o(2'b01, 2'b01, 2'b01, 2'b01, 2'b00);
    pat[1] = o(2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
    pat[2] = o(2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 2'b01, 1'b0, 16'd3, '0);
    for (int i = 0; i < 9; i++) add(2'b01, 2'b00, 1'b0, 16'd0, pat[i % 3]);
    add(2'b00, 2'b00, 1'b0, 16'd0, '0);
    for (int i = 0; plan.size() > 0; i++) begin
      step_t p = plan.pop_front();
      en = p.en; ld = p.ld; sync = p.sy; div_in = p.dv;
      sb.push_back(p.ex);
      tick();
      e = sb.pop_front(); n_chk++;
      if (obs !== e) begin n_fail++; $display("FAIL h3[%0d] obs=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_ld_pend();
    obs_t e;
    add(2'b00, 2'b01, 1'b0, 16'd4, '0);
    add(2'b01, 2'b00, 1'b0, 16'd0, o(2'b01, 2'b01, 2'b01, 2'b01, 2'b00));
    add(2'b01, 2'b01, 1'b0, 16'd2, o(2'b01, 2'b01, 2'b00, 2'b01, 2'b01));
    add(2'b01, 2'b00, 1'b0, 16'd0, o(2'b00, 2'b00, 2'b00, 2'b01, 2'b01));
    add(2'b01, 2'b00, 1'b0, 16'd0, o(2'b00, 2'b00, 2'b00, 2'b01, 2'b01));
    for (int i = 0; i < 2; i++) begin
      add(2'b01, 2'b00, 1'b0, 16'd0, o(2'b01, 2'b01, 2'b01, 2'b01, 2'b00));
      add(2'b01, 2'b00, 1'b0, 16'd0, o(2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
    end
    add(2'b00, 2'b00, 1'b0, 16'd0, '0);
    for (int i = 0; plan.size() > 0; i++) begin
      step_t p = plan.pop_front();
      en = p.en; ld = p.ld; sync = p.sy; div_in = p.dv;
      sb.push_back(p.ex);
      tick();
      e = sb.pop_front(); n_chk++;
      if (obs !== e) begin n_fail++; $display("FAIL ld_pend[%0d] obs=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_disable();
    obs_t e;
    obs_t hi, hip, lo;
    hip = o(2'b01, 2'b01, 2'b01, 2'b01, 2'b00);
    hi  = o(2'b01, 2'b01, 2'b00, 2'b01, 2'b00);
    lo  = o(2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 2'b01, 1'b0, 16'd4, '0);
    add(2'b01, 2'b00, 1'b0, 16'd0, hip);
    add(2'b00, 2'b00, 1'b0, 16'd0, hi);                        // en dropped at c=1
    add(2'b00, 2'b00, 1'b0, 16'd0, lo);
    add(2'b00, 2'b00, 1'b0, 16'd0, lo);
    add(2'b00, 2'b00, 1'b0, 16'd0, '0);
    add(2'b00, 2'b00, 1'b0, 16'd0, '0);
    add(2'b01, 2'b00, 1'b0, 16'd0, hip);
    add(2'b00, 2'b00, 1'b0, 16'd0, hi);
    add(2'b01, 2'b00, 1'b0, 16'd0, lo);                        // re-assert cancels the stop
    add(2'b01, 2'b00, 1'b0, 16'd0, lo);
    add(2'b01, 2'b00, 1'b0, 16'd0, hip);
    add(2'b00, 2'b00, 1'b0, 16'd0, hi);
    add(2'b00, 2'b00, 1'b0, 16'd0, lo);
    add(2'b00, 2'b00, 1'b0, 16'd0, lo);
    add(2'b00, 2'b00, 1'b0, 16'd0, '0);
    for (int i = 0; plan.size() > 0; i++) begin
      step_t p = plan.pop_front();
      en = p.en; ld = p.ld; sync = p.sy; div_in = p.dv;
      sb.push_back(p.ex);
      tick();
      e = sb.pop_front(); n_chk++;
      if (obs !== e) begin n_fail++; $display("FAIL disable[%0d] obs=%h exp=%h", i, obs, e); end
    end
  endtask

  task automatic test_sync();
    obs_t e;
    add(2'b00, 2'b11, 1'b0, {8'd3, 8'd5}, '0);
    add(2'b11, 2'b00, 1'b0, 16'd0, o(2'b11, 2'b11, 2'b11, 2'b11, 2'b00));
    add(2'b11, 2'b00, 1'b0, 16'd0, o(2'b11, 2'b01, 2'b00, 2'b11, 2'b00));
    add(2'b11, 2'b00, 1'b1, 16'd0, o(2'b11, 2'b11, 2'b11, 2'b11, 2'b00));
    add(2'b11, 2'b00, 1'b0, 16'd0, o(2'b11, 2'b01, 2'b00, 2'b11, 2'b00));
    add(2'b11, 2'b00, 1'b0, 16'd0, o(2'b01, 2'b00, 2'b00, 2'b11, 2'b00));
    add(2'b11, 2'b00, 1'b0, 16'd0, o(2'b10, 2'b10, 2'b10, 2'b11, 2'b00));
    add(2'b00, 2'b00, 1'b1, 16'd0, o(2'b11, 2'b11, 2'b11, 2'b11, 2'b00)); // sync beats en=0
    add(2'b00, 2'b00, 1'b0, 16'd0, o(2'b11, 2'b01, 2'b00, 2'b11, 2'b00));
    add(2'b00, 2'b00, 1'b0, 16'd0, o(2'b01, 2'b00, 2'b00, 2'b11, 2'b00));
    add(2'b00, 2'b00, 1'b0, 16'd0, o(2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
    add(2'b00, 2'b00, 1'b0, 16'd0, o(2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
    add(2'b00, 2'b00, 1'b0, 16'd0, '0);
    add(2'b00, 2'b00, 1'b1, 16'd0, '0);
    for (int i = 0; plan.size() > 0; i++) begin
      step_t p = plan.pop_front();
      en = p.en; ld = p.ld; sync = p.sy; div_in = p.dv;
      sb.push_back(p.ex);
      tick();
      e = sb.pop_front(); n_chk++;
      if (obs !== e) begin n_fail++; $display("FAIL sync[%0d] obs=%h exp=%h", i, obs, e); end
    end
    sync = 1'b0;
  endtask

  task automatic test_h255_reset();
    obs_t e;
    int   halves = 0;
    en = 2'b00; ld = 2'b01; div_in = {8'd0, 8'd255};
    sb.push_back('0);
    tick();
    e = sb.pop_front(); n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL h255_load obs=%h exp=%h", obs, e); end
    ld = 2'b00; en = 2'b01;
    for (int i = 0; i < 300; i++) begin
      int k = i % 255;
      sb.push_back(o({1'b0, k < 128}, {1'b0, k < 127}, {1'b0, k == 0}, 2'b01, 2'b00));
      tick();
      if (i < 255) halves += int'(q_rise[0]) + int'(q_fall[0]);
      e = sb.pop_front(); n_chk++;
      if (obs !== e) begin n_fail++; $display("FAIL h255[%0d] obs=%h exp=%h", i, obs, e); end
    end
    n_chk++;
    if (halves != 255) begin n_fail++; $display("FAIL h255_halves got=%0d exp=255", halves); end
    reset_n = 1'b0;
    #1;
    sb.push_back('0);
    e = sb.pop_front(); n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL async_reset obs=%h exp=%h", obs, e); end
    #2 reset_n = 1'b1;
    sb.push_back(o(2'b01, 2'b00, 2'b01, 2'b01, 2'b00));     // divisor back to 1, slot 0 first
    tick();
    e = sb.pop_front(); n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL post_reset obs=%h exp=%h", obs, e); end
    en = 2'b00;
    sb.push_back('0);
    tick();
    e = sb.pop_front(); n_chk++;
    if (obs !== e) begin n_fail++; $display("FAIL post_reset_stop obs=%h exp=%h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_h1();
    test_h3();
    test_ld_pend();
    test_disable();
    test_sync();
    test_h255_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
